// File: rtl/fifo_sync_param_pkg.sv
// Shared types and sizing helpers for the parametrised synchronous FIFO.
// Pointer wrap is explicit so non-power-of-2 depths work.
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  function automatic int ptr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_inc(input int ptr, input int depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_sync_param_if.sv
// Producer/consumer-facing bundle of the FIFO: write side, read side, status flags.
interface fifo_sync_param_if #(
  parameter int fifo_width = 8,
  parameter int fifo_depth = 8
);
  import fifo_pkg::*;

  localparam int cnt_width = cnt_w(fifo_depth);

  logic [fifo_width-1:0] fifo_data_in;
  logic                  fifo_write;
  logic                  fifo_read;
  logic                  fifo_clr_err;
  logic [fifo_width-1:0] fifo_data_out;
  logic                  fifo_data_valid;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_almost_full;
  logic                  fifo_almost_empty;
  logic [cnt_width-1:0]  fifo_cnt;
  logic                  fifo_overflow;
  logic                  fifo_underflow;

  modport master (
    output fifo_data_in, fifo_write, fifo_read, fifo_clr_err,
    input  fifo_data_out, fifo_data_valid, fifo_full, fifo_empty,
           fifo_almost_full, fifo_almost_empty, fifo_cnt,
           fifo_overflow, fifo_underflow
  );

  modport slave (
    input  fifo_data_in, fifo_write, fifo_read, fifo_clr_err,
    output fifo_data_out, fifo_data_valid, fifo_full, fifo_empty,
           fifo_almost_full, fifo_almost_empty, fifo_cnt,
           fifo_overflow, fifo_underflow
  );

endinterface

// File: rtl/fifo_sync_param_mem.sv
// Storage array for the FIFO: one synchronous write port, one asynchronous read port.
// Kept separate so it can be swapped for a RAM macro.
module fifo_mem #(
  parameter int mem_width  = 8,
  parameter int mem_depth  = 8,
  parameter int addr_width = 3
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [addr_width-1:0] wr_addr,
  input  logic [mem_width-1:0]  wr_data,
  input  logic [addr_width-1:0] rd_addr,
  output logic [mem_width-1:0]  rd_data
);

  logic [mem_width-1:0] mem [mem_depth];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised synchronous FIFO: any depth >= 2, programmable almost thresholds,
// standard (1-cycle) or first-word-fall-through read, sticky overflow/underflow.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int fifo_width     = 8,
  parameter int fifo_depth     = 8,
  parameter int fifo_afull_th  = fifo_depth - 1,
  parameter int fifo_aempty_th = 1,
  parameter int fifo_fwft      = 0
) (
  input  logic              clk,
  input  logic              rst,
  fifo_sync_param_if.slave  bus
);

  localparam int         ptr_width = ptr_w(fifo_depth);
  localparam int         cnt_width = cnt_w(fifo_depth);
  localparam fifo_mode_e mode      = (fifo_fwft != 0) ? FIFO_FWFT : FIFO_STD;

  if (fifo_depth < 2 || fifo_afull_th > fifo_depth || fifo_aempty_th >= fifo_depth) begin : g_bad_cfg
    $error("fifo_sync_param: illegal depth/threshold combination");
  end

  logic [ptr_width-1:0]  rd_ptr;
  logic [ptr_width-1:0]  wr_ptr;
  logic [cnt_width-1:0]  cnt;
  logic                  full;
  logic                  empty;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  overflow;
  logic                  underflow;
  logic [fifo_width-1:0] rd_data;

  assign empty  = (cnt == '0);
  assign full   = (cnt == cnt_width'(fifo_depth));
  assign rd_acc = bus.fifo_read && !empty;
  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign wr_acc = bus.fifo_write && (!full || rd_acc);

  fifo_mem #(
    .mem_width  (fifo_width),
    .mem_depth  (fifo_depth),
    .addr_width (ptr_width)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (bus.fifo_data_in),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_width'(ptr_inc(int'(wr_ptr), fifo_depth));
      if (rd_acc) rd_ptr <= ptr_width'(ptr_inc(int'(rd_ptr), fifo_depth));
      if (wr_acc && !rd_acc)      cnt <= cnt + cnt_width'(1);
      else if (rd_acc && !wr_acc) cnt <= cnt - cnt_width'(1);
    end
  end

  // Setting a flag takes priority over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (bus.fifo_write && !wr_acc) overflow <= 1'b1;
      else if (bus.fifo_clr_err)     overflow <= 1'b0;
      if (bus.fifo_read && !rd_acc)  underflow <= 1'b1;
      else if (bus.fifo_clr_err)     underflow <= 1'b0;
    end
  end

  if (mode == FIFO_STD) begin : g_std
    logic [fifo_width-1:0] dout_q;
    logic                  valid_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dout_q  <= '0;
        valid_q <= 1'b0;
      end else if (rd_acc) begin
        dout_q  <= rd_data;
        valid_q <= 1'b1;
      end else begin
        valid_q <= 1'b0;
      end
    end

    assign bus.fifo_data_out   = dout_q;
    assign bus.fifo_data_valid = valid_q;
  end else begin : g_fwft
    assign bus.fifo_data_out   = rd_data;
    assign bus.fifo_data_valid = !empty;
  end

  assign bus.fifo_full         = full;
  assign bus.fifo_empty        = empty;
  assign bus.fifo_almost_full  = (cnt >= cnt_width'(fifo_afull_th));
  assign bus.fifo_almost_empty = (cnt <= cnt_width'(fifo_aempty_th));
  assign bus.fifo_cnt          = cnt;
  assign bus.fifo_overflow     = overflow;
  assign bus.fifo_underflow    = underflow;

endmodule
